// File: rtl/ro_meas_pkg.sv
// Shared types and constants for the RO-PUF pair measurement block.
package ro_meas_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        COUNT  = 3'd2,
        DRAIN  = 3'd3,
        RESULT = 3'd4
    } ro_state_t;

    localparam int DRAIN_CYC = 3;
    localparam int CNT_W_DEF = 16;
    localparam int WIN_W_DEF = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronizes one ring-oscillator output, detects its rising edges and counts them.
// RO_MEAS_SAT_EN: counter saturates at all-ones and reports it on sat.
module ro_edge_counter
    import ro_meas_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro,
    input  logic             clr,
    input  logic             cnt_en,
    output logic [CNT_W-1:0] count
`ifdef RO_MEAS_SAT_EN
    ,
    output logic             sat
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // sync[0..1] is the two-flop synchronizer, sync[2] the edge-detect history
    logic [2:0] sync;
    logic       rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 3'b000;
        end else begin
            sync <= {sync[1:0], ro};
        end
    end

    assign rise = sync[1] & ~sync[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (cnt_en && rise) begin
`ifdef RO_MEAS_SAT_EN
            if (!(&count)) begin
                count <= count + CNT_ONE;
            end
`else
            count <= count + CNT_ONE;
`endif
        end
    end

`ifdef RO_MEAS_SAT_EN
    assign sat = &count;
`endif

endmodule

// File: rtl/ro_pair_counter.sv
// Enables one RO pair, counts both for a programmable window and returns a PUF bit.
// RO_MEAS_SAT_EN: saturating counters plus an overflow output.
//
// state  | meaning
// IDLE   | waiting for start, ROs off
// SETTLE | ROs running, counting inhibited for SETTLE_CYC cycles
// COUNT  | edges counted for window_len cycles
// DRAIN  | ROs off, synchronizers flushed, edges discarded
// RESULT | response held until resp_ready
module ro_pair_counter
    import ro_meas_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int WIN_W      = WIN_W_DEF,
    parameter int SETTLE_CYC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIN_W-1:0] window_len,
    input  logic             ro_a,
    input  logic             ro_b,
    output logic             ro_en_a,
    output logic             ro_en_b,
    output logic             busy,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_bit,
    output logic             tie,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b
`ifdef RO_MEAS_SAT_EN
    ,
    output logic             overflow
`endif
);

    // timer must hold the settle, window and drain reloads
    localparam int TMR_W = max_int(WIN_W, 8);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] DRAIN_LD  = TMR_W'(DRAIN_CYC - 1);

    ro_state_t        state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [WIN_W-1:0] win_q;
    logic             load_win;
    logic             clr_cnt;
    logic             latch_res;
    logic             cnt_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tmr   <= '0;
            win_q <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            if (load_win) begin
                win_q <= window_len;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        load_win  = 1'b0;
        clr_cnt   = 1'b0;
        latch_res = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SETTLE;
                    tmr_nxt   = SETTLE_LD;
                    load_win  = 1'b1;
                    clr_cnt   = 1'b1;
                end
            end
            SETTLE: begin
                if (tmr == '0) begin
                    if (win_q == '0) begin
                        state_nxt = DRAIN;
                        tmr_nxt   = DRAIN_LD;
                    end else begin
                        state_nxt = COUNT;
                        tmr_nxt   = TMR_W'(win_q) - TMR_ONE;
                    end
                end else begin
                    tmr_nxt = tmr - TMR_ONE;
                end
            end
            COUNT: begin
                if (tmr == '0) begin
                    state_nxt = DRAIN;
                    tmr_nxt   = DRAIN_LD;
                end else begin
                    tmr_nxt = tmr - TMR_ONE;
                end
            end
            DRAIN: begin
                if (tmr == '0) begin
                    state_nxt = RESULT;
                    latch_res = 1'b1;
                end else begin
                    tmr_nxt = tmr - TMR_ONE;
                end
            end
            RESULT: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign cnt_en     = (state == COUNT);
    assign ro_en_a    = (state == SETTLE) || (state == COUNT);
    assign ro_en_b    = (state == SETTLE) || (state == COUNT);
    assign busy       = (state != IDLE);
    assign resp_valid = (state == RESULT);

`ifdef RO_MEAS_SAT_EN
    logic sat_a, sat_b;
    logic ovf_q;
`endif

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk    (clk),
        .rst    (rst),
        .ro     (ro_a),
        .clr    (clr_cnt),
        .cnt_en (cnt_en),
        .count  (count_a)
`ifdef RO_MEAS_SAT_EN
        ,
        .sat    (sat_a)
`endif
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk    (clk),
        .rst    (rst),
        .ro     (ro_b),
        .clr    (clr_cnt),
        .cnt_en (cnt_en),
        .count  (count_b)
`ifdef RO_MEAS_SAT_EN
        ,
        .sat    (sat_b)
`endif
    );

    // counts are frozen during DRAIN, so the compare is taken on its last cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_bit <= 1'b0;
            tie      <= 1'b0;
        end else if (latch_res) begin
            resp_bit <= (count_a > count_b);
            tie      <= (count_a == count_b);
        end
    end

`ifdef RO_MEAS_SAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (clr_cnt) begin
            ovf_q <= 1'b0;
        end else if (latch_res) begin
            ovf_q <= sat_a | sat_b;
        end
    end

    assign overflow = ovf_q;
`endif

endmodule

// File: doc/ro_pair_counter.md
Name: ro_pair_counter

Overview:
- Measurement end of the RO-PUF ring oscillators: enables one selected pair of ring oscillators and counts their rising edges over a programmable window of clk cycles.
- Compares the two counts and returns one PUF response bit plus raw counts over a valid/ready handshake.
- Sits between the RO array (ring oscillator enable/out pins) and the PUF challenge/response controller.

Parameters:
- CNT_W, 16, width of each edge counter and of count_a/count_b.
- WIN_W, 16, width of window_len.
- SETTLE_CYC, 8, clk cycles the ROs run enabled before counting starts; range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- window_len  in  WIN_W  count window in clk cycles; sampled when start is accepted.
- ro_a  in  1  raw output of oscillator A; asynchronous to clk.
- ro_b  in  1  raw output of oscillator B; asynchronous to clk.
- ro_en_a  out  1  enable to oscillator A.
- ro_en_b  out  1  enable to oscillator B.
- busy  out  1  high from the cycle after start is accepted until the response is consumed.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_bit  out  1  1 when count_a > count_b, else 0.
- tie  out  1  count_a == count_b.
- count_a  out  CNT_W  rising edges of ro_a in the window.
- count_b  out  CNT_W  rising edges of ro_b in the window.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, synchronizer flops 0.
- ro_a/ro_b each pass through a 2-flop synchronizer, then a rising-edge detector (sync2 & ~sync3).
- Valid measurement requires RO frequency < fclk/2; the block does not detect violations.
- FSM states:
  - IDLE: start=1 → latch window_len, clear counters, go to SETTLE. ro_en_a/b go high on the entry cycle.
  - SETTLE: ROs enabled, counting inhibited, for exactly SETTLE_CYC cycles → COUNT. If the latched window_len=0, go directly to DRAIN with counts 0.
  - COUNT: counters increment on detected edges for exactly window_len cycles → DRAIN. ro_en stays high through the last COUNT cycle.
  - DRAIN: ro_en low, counting inhibited for 3 cycles to flush the synchronizers. Edges detected in DRAIN are discarded. → RESULT.
  - RESULT: resp_valid=1. resp_bit, tie and counts are registered and held stable while resp_valid is high. resp_ready=1 → IDLE next cycle, resp_valid and busy drop.
- Latency from start to resp_valid: 1 + SETTLE_CYC + window_len + 3 cycles.
- start outside IDLE is ignored. start and resp_ready asserted in the same cycle in RESULT: only the handshake completes; start is not queued.
- Tie: tie=1, resp_bit=0.
- Counter overflow: wraps modulo 2^CNT_W (default build).
- rst mid-operation: return to IDLE within one cycle, ro_en low, any pending response discarded.
- count_a/count_b keep the last result until the next start clears them.

Optional Feature:
- Macro: RO_MEAS_SAT_EN.
- Defined: each counter saturates at all-ones. An extra output port, overflow (1 bit), is high in RESULT if either counter saturated, and clears on the next start.
- Undefined: counters wrap and no overflow port exists.

Decomposition:
- Package ro_meas_pkg holds:
  - FSM state enum: IDLE, SETTLE, COUNT, DRAIN, RESULT.
  - DRAIN_CYC = 3.
  - Default CNT_W and WIN_W constants.
- Sub-module ro_edge_counter: synchronizer, edge detect, count enable and clear, and the optional saturation. Instantiated once per oscillator.

Test Plan:
- Reset release: all outputs 0; ro_en_a/b stay 0 with no start for 100 cycles.
- ro_a period 6 clk, ro_b period 8 clk, window_len=240 → count_a 40±1, count_b 30±1, resp_bit=1, tie=0. resp_valid rises exactly 1+8+240+3 cycles after start.
- Identical period-10 waveforms, in phase, window_len=100 → count_a=count_b=10, tie=1, resp_bit=0.
- window_len=0 → counts 0, tie=1. resp_valid after 1+8+3 cycles. ro_en high only during SETTLE.
- Hold resp_ready=0 for 20 cycles, pulse start meanwhile → outputs stable, start ignored. resp_ready=1 → IDLE next cycle.
- CNT_W=4, ro_a period 4, window_len=80 → 20 edges: count_a=4 (wrap). With RO_MEAS_SAT_EN: count_a=15, overflow=1.
- Additional scenario: assert rst in the middle of COUNT → next cycle ro_en=0, busy=0, resp_valid=0.
